// File: rtl/rpi_rd_port.sv
// Raspberry Pi parallel read port: a synchronised read strobe captures one of eight sources into a shadow register.
// Optional macro RD_ACK_EN enables the ACK handshake; without it ACK is tied low and the Pi relies on fixed latency.
module rpi_rd_port #(
  parameter int SYNC_STAGES   = 2,
  parameter int KEY_DB_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RD_IMP,
  input  logic [2:0]  SEL,
  input  logic [59:0] SRC,
  input  logic [1:0]  KEY,
  output logic [9:0]  BUS_OUT,
  output logic        BUS_OE,
  output logic        ACK,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAPT  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_TURN  = 2'd3
  } state_t;

  localparam int DBW = $clog2(KEY_DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(KEY_DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0]      r_rd_sync;
  logic [SYNC_STAGES-1:0][2:0] r_sel_sync;
  logic [SYNC_STAGES-1:0][1:0] r_key_sync;
  logic                        r_rd_d;

  logic                        w_rd_s;
  logic [2:0]                  w_sel_s;
  logic [1:0]                  w_key_s;
  logic                        w_rd_rise;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        w_load;
  logic [9:0]                  r_shadow;
  logic [9:0]                  w_src_sel;

  logic [1:0]                  r_key_db;
  logic [DBW-1:0]              r_db_cnt [2];
  logic [1:0]                  w_press;
  logic [1:0]                  w_clr;
  logic [9:0]                  r_press_cnt [2];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_sync  <= '0;
      r_sel_sync <= '0;
      r_key_sync <= '0;
      r_rd_d     <= 1'b0;
    end else begin
      r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], RD_IMP};
      r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], SEL};
      r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], KEY};
      r_rd_d     <= w_rd_s;
    end
  end

  assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
  assign w_sel_s   = r_sel_sync[SYNC_STAGES-1];
  assign w_key_s   = r_key_sync[SYNC_STAGES-1];
  assign w_rd_rise = w_rd_s & ~r_rd_d;

  // A press is the cycle on which the debounced level is accepted as going 1->0.
  always_comb begin
    w_press = '0;
    for (int i = 0; i < 2; i++) begin
      w_press[i] = r_key_db[i] & ~w_key_s[i] & (r_db_cnt[i] == DB_LAST);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_key_db <= 2'b11;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_key_s[i] != r_key_db[i]) begin
          if (r_db_cnt[i] == DB_LAST) begin
            r_key_db[i] <= w_key_s[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_load   = ((r_state == ST_IDLE) && w_rd_rise) || ((r_state == ST_TURN) && w_rd_s);
  assign w_clr[0] = w_load && (w_sel_s == 3'd6);
  assign w_clr[1] = w_load && (w_sel_s == 3'd7);

  // Capture clears the counter; a press landing on the same cycle survives as a count of 1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) r_press_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_clr[i]) begin
          r_press_cnt[i] <= {9'd0, w_press[i]};
        end else if (w_press[i] && (r_press_cnt[i] != 10'h3FF)) begin
          r_press_cnt[i] <= r_press_cnt[i] + 10'd1;
        end
      end
    end
  end

  always_comb begin
    w_src_sel = '0;
    case (w_sel_s)
      3'd0:    w_src_sel = SRC[9:0];
      3'd1:    w_src_sel = SRC[19:10];
      3'd2:    w_src_sel = SRC[29:20];
      3'd3:    w_src_sel = SRC[39:30];
      3'd4:    w_src_sel = SRC[49:40];
      3'd5:    w_src_sel = SRC[59:50];
      3'd6:    w_src_sel = r_press_cnt[0];
      default: w_src_sel = r_press_cnt[1];
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_shadow <= w_src_sel;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_rd_rise) w_state_nxt = ST_CAPT;
      ST_CAPT:  w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (!w_rd_s) w_state_nxt = ST_TURN;
      ST_TURN:  w_state_nxt = w_rd_s ? ST_CAPT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode the async-reset state register so reset drops them without a clock edge.
  assign BUS_OUT     = r_shadow;
  assign BUS_OE      = (r_state == ST_CAPT) || (r_state == ST_DRIVE);
  assign o_dbg_state = r_state;
`ifdef RD_ACK_EN
  assign ACK = (r_state == ST_DRIVE);
`else
  assign ACK = 1'b0;
`endif

endmodule

// File: doc/rpi_rd_port.md
RPI_RD_PORT -- requirements
Module: rpi_rd_port

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchroniser flops on RD_IMP, SEL and KEY (legal 2..4).
REQ-002 Parameter KEY_DB_CYCLES, default 50000: consecutive stable cycles required to accept a KEY level change.
REQ-003 CLK  in  1  single system clock; all logic on its rising edge.
REQ-004 RST_N  in  1  asynchronous, active-low reset.
REQ-005 RD_IMP  in  1  read strobe from the Raspberry Pi, asynchronous to CLK; high means a read is in progress.
REQ-006 SEL  in  3  source select from the Pi, asynchronous; held stable by the Pi before RD_IMP rises.
REQ-007 SRC  in  60  six 10-bit parallel sources; SRC[10k+9:10k] is source k (k=0..5).
REQ-008 KEY  in  2  raw active-low push buttons.
REQ-009 BUS_OUT  out  10  read data toward the GPIO bus pins.
REQ-010 BUS_OE  out  1  tristate enable for the bus pins; 1 means the FPGA drives BUS_OUT.
REQ-011 ACK  out  1  data-valid indication to the Pi.

Function
REQ-012 RD_IMP, SEL and KEY each pass through SYNC_STAGES flops; all logic below uses only the synchronised copies (rd_s, sel_s, key_s).
REQ-013 rd_rise = rd_s 1 now and 0 on the previous cycle.
REQ-014 FSM states: IDLE, CAPT, DRIVE, TURN; reset state is IDLE.
REQ-015 IDLE: on rd_rise, load shadow <= source[sel_s] and go to CAPT; otherwise stay in IDLE.
REQ-016 CAPT: BUS_OE=1, ACK=0; unconditionally go to DRIVE on the next cycle, even if rd_s has already fallen.
REQ-017 DRIVE: BUS_OE=1, ACK=1; go to TURN when rd_s=0, otherwise stay.
REQ-018 TURN: BUS_OE=0, ACK=0 for one cycle; if rd_s=1, reload shadow from source[sel_s] and go to CAPT; else go to IDLE.
REQ-019 IDLE: BUS_OE=0, ACK=0.
REQ-020 BUS_OUT = shadow at all times; shadow holds its value between reads.
REQ-021 Source map: sel 0..5 gives SRC slice k; sel 6 gives KEY[0] press count; sel 7 gives KEY[1] press count.
REQ-022 Debounce per key: the debounced level takes the key_s value once key_s has differed from it for KEY_DB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-023 A press is a debounced 1->0 transition; each press increments that key's 10-bit counter, saturating at 1023.
REQ-024 A counter clears when it is captured into shadow (sel 6 or 7); a press on the same cycle as the capture leaves the counter at 1, and shadow gets the pre-increment value.
REQ-025 Read latency: BUS_OE rises 1 cycle after rd_rise; ACK rises 2 cycles after rd_rise; both measured on synchronised timing.
REQ-026 Changes to SEL or SRC during CAPT or DRIVE do not alter BUS_OUT.

Reset
REQ-027 While RST_N=0: FSM=IDLE, BUS_OE=0, ACK=0, shadow=0, both press counters=0, all synchroniser flops=0, debounced key levels=1, debounce counters=0.
REQ-028 Reset asserted mid-read drops BUS_OE and ACK immediately (asynchronously); after release, a read needs a fresh rd_rise.

Configuration
REQ-029 Macro RD_ACK_EN: when defined, ACK behaves as in REQ-016..REQ-019; when undefined, ACK is constant 0, the FSM timing is unchanged, and the Pi relies on fixed latency.

Verification
REQ-030 SRC slice 2 = 10'h2A5, SEL=2, RD_IMP pulse 10 cycles -> BUS_OUT=10'h2A5; BUS_OE high from rise+SYNC_STAGES+1; ACK one cycle later; both low after the fall plus sync delay.
REQ-031 Three clean KEY[0] presses (KEY_DB_CYCLES=4 in the bench), then a read with SEL=6 -> BUS_OUT=3; an immediate second read -> 0.
REQ-032 KEY[1] bounces shorter than KEY_DB_CYCLES -> SEL=7 read returns 0; 1100 presses -> 1023 (saturation).
REQ-033 RD_IMP low for a single cycle between two reads (SEL 0 then 1) -> FSM passes through TURN into CAPT; second read returns slice 1; BUS_OE low for exactly one cycle.
REQ-034 RST_N pulled low during DRIVE -> BUS_OE=0 and ACK=0 with no clock edge; after release, BUS_OUT=0 until the next rd_rise.
REQ-035 Build without RD_ACK_EN and repeat REQ-030 -> ACK stays 0 throughout; BUS_OUT and BUS_OE timing are identical to REQ-030.
